// File: rtl/aes_pkg.sv
// aes_pkg -- shared definitions for the AES round-trip self-test sequencer.
//   state_t      : sequencer states (IDLE, ENC_REQ, DEC_REQ, CHECK, DONE)
//   MODE_*       : key-length / run-mode encodings driven on the mode port
//   GF_POLY      : reduction constant used when doubling a message in GF(2^128)
//   gf_double()  : next test message from the current one
//   mode_valid() : true for any mode that actually starts a run
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENC_REQ = 3'd1,
    DEC_REQ = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_AES128 = 2'b01;
  localparam logic [1:0] MODE_AES192 = 2'b10;
  localparam logic [1:0] MODE_AES256 = 2'b11;

  localparam logic [127:0] GF_POLY = 128'h87;

  // Multiply by x in GF(2^128): shift left, fold the carried-out bit back in.
  function automatic logic [127:0] gf_double(input logic [127:0] v);
    return {v[126:0], 1'b0} ^ (v[127] ? GF_POLY : 128'h0);
  endfunction

  function automatic logic mode_valid(input logic [1:0] m);
    return (m == MODE_AES128) || (m == MODE_AES192) || (m == MODE_AES256);
  endfunction

endpackage

// File: rtl/aes_msg_lfsr.sv
// aes_msg_lfsr -- 128-bit test-message generator.
//   clk, reset : clock, synchronous active-high reset (state clears to 0)
//   load       : state <= seed
//   step       : state <= state * x in GF(2^128) (load has priority)
//   seed       : value loaded on load
//   state      : current message
module aes_msg_lfsr
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [127:0] seed,
  output logic [127:0] state
);

  logic [127:0] state_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= '0;
    end else if (load) begin
      state_reg <= seed;
    end else if (step) begin
      state_reg <= gf_double(state_reg);
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/aes_roundtrip_seq.sv
// aes_roundtrip_seq -- drives NUM_VECTORS messages through an external AES
// encrypt core and back through a decrypt core, counting round trips whose
// plaintext comes back unchanged.
//   clk, reset                 : clock, synchronous active-high reset
//   mode, start                : run mode (00 off) and run-request pulse
//   enc_req/key_len/data       : encrypt request, held until enc_ack
//   enc_ack, enc_result        : encrypt response pulse and ciphertext
//   dec_req/key_len/data       : decrypt request, held until dec_ack
//   dec_ack, dec_result        : decrypt response pulse and plaintext
//   byte_sel, disp_byte        : byte of the last captured plaintext
//   busy, pass_led, fail_led   : run status
//   pass_cnt, fail_cnt         : saturating result counters
// Build option: define AES_ACK_TIMEOUT_EN to add an ack watchdog that aborts
// the run to DONE (counting one failure) after TIMEOUT_CYCLES cycles without ack.
module aes_roundtrip_seq
  import aes_pkg::*;
#(
  parameter int           NUM_VECTORS    = 4,
  parameter int           CNT_W          = 8,
  parameter logic [127:0] SEED           = 128'h00112233445566778899aabbccddeeff,
  parameter int           TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             start,
  output logic             enc_req,
  output logic [1:0]       enc_key_len,
  output logic [127:0]     enc_data,
  input  logic             enc_ack,
  input  logic [127:0]     enc_result,
  output logic             dec_req,
  output logic [1:0]       dec_key_len,
  output logic [127:0]     dec_data,
  input  logic             dec_ack,
  input  logic [127:0]     dec_result,
  input  logic [3:0]       byte_sel,
  output logic [7:0]       disp_byte,
  output logic             busy,
  output logic             pass_led,
  output logic             fail_led,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  state_t           state_reg, state_next;
  logic [1:0]       mode_reg;
  logic [7:0]       vec_idx_reg;
  logic [127:0]     ct_reg, pt_reg, msg;
  logic [CNT_W-1:0] pass_cnt_reg, fail_cnt_reg;
  logic             run_start, last_vec, idle_like, timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign run_start = start && mode_valid(mode);
  assign last_vec  = (vec_idx_reg == 8'(NUM_VECTORS - 1));
  assign idle_like = (state_reg == IDLE) || (state_reg == DONE);

  aes_msg_lfsr u_msg (
    .clk   (clk),
    .reset (reset),
    .load  (idle_like && run_start),
    .step  ((state_reg == CHECK) && !last_vec),
    .seed  (SEED),
    .state (msg)
  );

`ifdef AES_ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt_reg;

  // Counts cycles spent in the current request state; restarts on any move.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_reg <= '0;
    end else if (((state_reg == ENC_REQ) || (state_reg == DEC_REQ)) &&
                 (state_next == state_reg)) begin
      wait_cnt_reg <= wait_cnt_reg + TW'(1);
    end else begin
      wait_cnt_reg <= '0;
    end
  end

  // High during the last permitted request cycle.
  assign timeout = (wait_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; acks only count in their own request state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (run_start) state_next = ENC_REQ;
      ENC_REQ: begin
        if (enc_ack)      state_next = DEC_REQ;
        else if (timeout) state_next = DONE;
      end
      DEC_REQ: begin
        if (dec_ack)      state_next = CHECK;
        else if (timeout) state_next = DONE;
      end
      CHECK:   state_next = last_vec ? DONE : ENC_REQ;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latched mode, vector index, captured ct/pt, counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg     <= MODE_OFF;
      vec_idx_reg  <= '0;
      ct_reg       <= '0;
      pt_reg       <= '0;
      pass_cnt_reg <= '0;
      fail_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (run_start) begin
            mode_reg     <= mode;
            vec_idx_reg  <= '0;
            pass_cnt_reg <= '0;
            fail_cnt_reg <= '0;
          end
        end
        ENC_REQ: begin
          if (enc_ack)      ct_reg       <= enc_result;
          else if (timeout) fail_cnt_reg <= sat_inc(fail_cnt_reg);
        end
        DEC_REQ: begin
          if (dec_ack)      pt_reg       <= dec_result;
          else if (timeout) fail_cnt_reg <= sat_inc(fail_cnt_reg);
        end
        CHECK: begin
          if (pt_reg == msg) pass_cnt_reg <= sat_inc(pass_cnt_reg);
          else               fail_cnt_reg <= sat_inc(fail_cnt_reg);
          if (!last_vec)     vec_idx_reg  <= vec_idx_reg + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the registered state so they drop on the same
  // edge that leaves a state (including reset).
  always_comb begin
    enc_req     = 1'b0;
    enc_key_len = 2'b00;
    enc_data    = '0;
    dec_req     = 1'b0;
    dec_key_len = 2'b00;
    dec_data    = '0;
    busy        = 1'b0;
    pass_led    = 1'b0;
    fail_led    = 1'b0;
    case (state_reg)
      ENC_REQ: begin
        enc_req     = 1'b1;
        enc_key_len = mode_reg;
        enc_data    = msg;
        busy        = 1'b1;
      end
      DEC_REQ: begin
        dec_req     = 1'b1;
        dec_key_len = mode_reg;
        dec_data    = ct_reg;
        busy        = 1'b1;
      end
      CHECK: busy = 1'b1;
      DONE: begin
        pass_led = (fail_cnt_reg == '0);
        fail_led = (fail_cnt_reg != '0);
      end
      default: ;
    endcase
  end

  assign disp_byte = pt_reg[{byte_sel, 3'b000} +: 8];
  assign pass_cnt  = pass_cnt_reg;
  assign fail_cnt  = fail_cnt_reg;

endmodule

// File: tb/tb_aes_roundtrip_seq.sv
module tb_aes_roundtrip_seq;

  localparam int           NV       = 4;
  localparam logic [127:0] SEED_VAL = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   mode;
  logic         start;
  logic         enc_req, dec_req;
  logic [1:0]   enc_key_len, dec_key_len;
  logic [127:0] enc_data, dec_data;
  logic         enc_ack, dec_ack;
  logic [127:0] enc_result, dec_result;
  logic [3:0]   byte_sel;
  logic [7:0]   disp_byte;
  logic         busy, pass_led, fail_led;
  logic [7:0]   pass_cnt, fail_cnt;

  always #5 clk = ~clk;

  aes_roundtrip_seq dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .start       (start),
    .enc_req     (enc_req),
    .enc_key_len (enc_key_len),
    .enc_data    (enc_data),
    .enc_ack     (enc_ack),
    .enc_result  (enc_result),
    .dec_req     (dec_req),
    .dec_key_len (dec_key_len),
    .dec_data    (dec_data),
    .dec_ack     (dec_ack),
    .dec_result  (dec_result),
    .byte_sel    (byte_sel),
    .disp_byte   (disp_byte),
    .busy        (busy),
    .pass_led    (pass_led),
    .fail_led    (fail_led),
    .pass_cnt    (pass_cnt),
    .fail_cnt    (fail_cnt)
  );

  typedef struct {
    logic [127:0] data;
    logic [1:0]   klen;
  } req_t;

  req_t         enc_q[$];
  req_t         dec_q[$];
  int           compared   = 0;
  int           mismatched = 0;
  bit           ack_enable = 1'b0;
  bit           corrupt_en = 1'b0;
  logic [127:0] corrupt_ct = '0;
  logic [127:0] key_pat    = '0;
  int           enc_seen   = 0;
  int           enc_req_cycles = 0;
  logic [127:0] second_enc = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference message sequence: each message is the previous one times x in GF(2^128).
  function automatic logic [127:0] next_msg(input logic [127:0] m);
    logic [128:0] wide;
    wide = {m, 1'b0};
    if (wide[128]) return wide[127:0] ^ 128'h87;
    return wide[127:0];
  endfunction

  // Encrypt core model: XOR with a per-run random pad, random latency,
  // plus stray acks while its own request is low.
  initial begin : enc_core
    int d;
    enc_ack = 1'b0;
    enc_result = '0;
    forever begin
      @(negedge clk);
      if (enc_req && ack_enable) begin
        d = $urandom_range(0, 3);
        for (int i = 0; i < d; i++) @(negedge clk);
        if (enc_req && ack_enable) begin
          enc_ack = 1'b1;
          enc_result = enc_data ^ key_pat;
          @(negedge clk);
          enc_ack = 1'b0;
          enc_result = {$urandom, $urandom, $urandom, $urandom};
        end
      end else if (!enc_req && ack_enable && $urandom_range(0, 3) == 0) begin
        enc_ack = 1'b1;
        enc_result = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        enc_ack = 1'b0;
      end
    end
  end

  initial begin : dec_core
    int d;
    dec_ack = 1'b0;
    dec_result = '0;
    forever begin
      @(negedge clk);
      if (dec_req && ack_enable) begin
        d = $urandom_range(0, 3);
        for (int i = 0; i < d; i++) @(negedge clk);
        if (dec_req && ack_enable) begin
          dec_ack = 1'b1;
          dec_result = dec_data ^ key_pat ^
                       ((corrupt_en && dec_data == corrupt_ct) ? 128'h1 : 128'h0);
          @(negedge clk);
          dec_ack = 1'b0;
          dec_result = {$urandom, $urandom, $urandom, $urandom};
        end
      end else if (!dec_req && ack_enable && $urandom_range(0, 3) == 0) begin
        dec_ack = 1'b1;
        dec_result = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        dec_ack = 1'b0;
      end
    end
  end

  // Monitor: pops the expected request on every handshake.
  initial begin : monitor
    req_t e;
    forever begin
      @(negedge clk);
      #2;
      if (enc_req) enc_req_cycles++;
      if (!reset && enc_req && enc_ack) begin
        $display("enc txn: data=%h klen=%b", enc_data, enc_key_len);
        if (enc_seen == 1) second_enc = enc_data;
        enc_seen++;
        if (enc_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL enc_unexpected: got data %h, expected no request", enc_data);
        end else begin
          e = enc_q.pop_front();
          check("enc_data", enc_data, e.data);
          check("enc_key_len", {126'h0, enc_key_len}, {126'h0, e.klen});
        end
      end
      if (!reset && dec_req && dec_ack) begin
        $display("dec txn: data=%h klen=%b", dec_data, dec_key_len);
        if (dec_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL dec_unexpected: got data %h, expected no request", dec_data);
        end else begin
          e = dec_q.pop_front();
          check("dec_data", dec_data, e.data);
          check("dec_key_len", {126'h0, dec_key_len}, {126'h0, e.klen});
        end
      end
    end
  end

  task automatic pulse_start(input logic [1:0] m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One full run; cvec = vector whose decrypt is corrupted (-1 for none).
  task automatic do_run(input logic [1:0] m, input int cvec, input bit change_mode);
    logic [127:0] msg, last_pt;
    int           exp_pass, exp_fail, n;
    key_pat  = {$urandom, $urandom, $urandom, $urandom};
    msg      = SEED_VAL;
    exp_pass = 0;
    exp_fail = 0;
    last_pt  = '0;
    corrupt_en = (cvec >= 0);
    for (int v = 0; v < NV; v++) begin
      enc_q.push_back('{data: msg, klen: m});
      dec_q.push_back('{data: msg ^ key_pat, klen: m});
      if (v == cvec) begin
        corrupt_ct = msg ^ key_pat;
        last_pt    = msg ^ 128'h1;
        exp_fail++;
      end else begin
        last_pt = msg;
        exp_pass++;
      end
      msg = next_msg(msg);
    end
    enc_seen = 0;
    pulse_start(m);
    check("busy_after_start", {127'h0, busy}, 128'h1);
    if (change_mode) begin
      repeat (3) @(negedge clk);
      mode  = 2'b01;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      compared++;
      mismatched++;
      $display("FAIL run_timeout: got busy=1 after %0d cycles, expected busy=0", n);
    end
    $display("run done: mode=%b corrupt=%0d pass_cnt=%0d fail_cnt=%0d", m, cvec, pass_cnt, fail_cnt);
    check("pass_cnt", {120'h0, pass_cnt}, 128'(exp_pass));
    check("fail_cnt", {120'h0, fail_cnt}, 128'(exp_fail));
    check("pass_led", {127'h0, pass_led}, (exp_fail == 0) ? 128'h1 : 128'h0);
    check("fail_led", {127'h0, fail_led}, (exp_fail != 0) ? 128'h1 : 128'h0);
    check("enc_q_empty", 128'(enc_q.size()), 128'h0);
    check("dec_q_empty", 128'(dec_q.size()), 128'h0);
    for (int b = 0; b < 16; b++) begin
      byte_sel = 4'(b);
      #1;
      check("disp_byte", {120'h0, disp_byte}, {120'h0, last_pt[b*8 +: 8]});
    end
    enc_q.delete();
    dec_q.delete();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin : stimulus
    logic [127:0] exp_second;
    int           n;
    exp_second = 128'h0022446688aacceF1133557799bbddfe;
    reset    = 1'b1;
    mode     = 2'b00;
    start    = 1'b0;
    byte_sel = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_enc_req", {127'h0, enc_req}, 128'h0);
    check("rst_dec_req", {127'h0, dec_req}, 128'h0);
    check("rst_busy", {127'h0, busy}, 128'h0);
    check("rst_leds", {126'h0, pass_led, fail_led}, 128'h0);
    check("rst_counters", {112'h0, pass_cnt, fail_cnt}, 128'h0);
    check("rst_disp_byte", {120'h0, disp_byte}, 128'h0);
    check("rst_enc_data", enc_data, 128'h0);
    reset = 1'b0;
    ack_enable = 1'b1;

    do_run(2'b01, -1, 1'b0);
    check("second_enc_data", second_enc, exp_second);

    do_run(2'($urandom_range(1, 3)), 1, 1'b0);
    do_run(2'b11, -1, 1'b1);

    // mode 00 start is ignored: no request, not busy
    enc_req_cycles = 0;
    pulse_start(2'b00);
    repeat (10) @(negedge clk);
    check("off_no_req", 128'(enc_req_cycles), 128'h0);
    check("off_not_busy", {127'h0, busy}, 128'h0);

    for (int r = 0; r < 4; r++)
      do_run(2'($urandom_range(1, 3)), $urandom_range(0, NV) - 1, 1'b0);

    // Reset while a request is pending
    ack_enable = 1'b0;
    pulse_start(2'b10);
    n = 0;
    while (!enc_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen_before_reset", {127'h0, enc_req}, 128'h1);
    reset = 1'b1;
    @(negedge clk);
    check("rr_enc_req", {127'h0, enc_req}, 128'h0);
    check("rr_busy", {127'h0, busy}, 128'h0);
    check("rr_counters", {112'h0, pass_cnt, fail_cnt}, 128'h0);
    check("rr_leds", {126'h0, pass_led, fail_led}, 128'h0);
    byte_sel = 4'd5;
    #1;
    check("rr_disp_byte", {120'h0, disp_byte}, 128'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rr_stays_idle", {126'h0, enc_req, busy}, 128'h0);
    enc_q.delete();
    dec_q.delete();
    ack_enable = 1'b1;
    do_run(2'b10, -1, 1'b0);

`ifdef AES_ACK_TIMEOUT_EN
    ack_enable = 1'b0;
    enc_req_cycles = 0;
    pulse_start(2'b01);
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("to_req_cycles", 128'(enc_req_cycles), 128'd64);
    check("to_fail_cnt", {120'h0, fail_cnt}, 128'h1);
    check("to_pass_cnt", {120'h0, pass_cnt}, 128'h0);
    check("to_fail_led", {127'h0, fail_led}, 128'h1);
    ack_enable = 1'b1;
`endif

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/aes_roundtrip_seq.md
AES_ROUNDTRIP_SEQ -- requirements
Module: aes_roundtrip_seq

Interface
REQ-001 Parameter NUM_VECTORS, default 4: vectors per run, 1..255.
REQ-002 Parameter CNT_W, default 8: width of the pass and fail counters.
REQ-003 Parameter SEED, default 128'h00112233445566778899aabbccddeeff: message for vector 0.
REQ-004 Parameter TIMEOUT_CYCLES, default 64: ack watchdog limit; used only when the macro in REQ-024 is defined.
REQ-005 Ports: clk in 1 clock; reset in 1 reset, synchronous, active-high; clock clk.
REQ-006 Run-control ports: mode in 2 (00 off, 01 AES-128, 10 AES-192, 11 AES-256); start in 1 run-request pulse.
REQ-007 Encrypt-core ports: enc_req out 1; enc_key_len out 2; enc_data out 128; enc_ack in 1 one-cycle pulse; enc_result in 128.
REQ-008 Decrypt-core ports: dec_req out 1; dec_key_len out 2; dec_data out 128; dec_ack in 1; dec_result in 128.
REQ-009 Display ports: byte_sel in 4; disp_byte out 8.
REQ-010 Status ports: busy out 1; pass_led out 1; fail_led out 1; pass_cnt out CNT_W; fail_cnt out CNT_W.

Function
REQ-011 States SHALL be IDLE, ENC_REQ, DEC_REQ, CHECK and DONE.
REQ-012 IDLE -> ENC_REQ on start=1 with mode!=00: latch mode, vec_idx=0, msg=SEED, clear both counters.
REQ-013 In IDLE, start with mode=00 SHALL be ignored.
REQ-014 In ENC_REQ, enc_req=1, enc_data=msg and enc_key_len=latched mode SHALL be held until enc_ack.
REQ-015 On enc_ack: capture ct=enc_result and go to DEC_REQ; enc_req deasserts on the same edge.
REQ-016 DEC_REQ SHALL mirror REQ-014/REQ-015 with dec_data=ct; capture pt=dec_result, then go to CHECK.
REQ-017 CHECK, one cycle: pt==msg increments pass_cnt, otherwise fail_cnt; counters saturate at all-ones.
REQ-018 Leaving CHECK: if vec_idx==NUM_VECTORS-1 go to DONE; else vec_idx++, msg={msg[126:0],1'b0}^(msg[127]?128'h87:0), go to ENC_REQ.
REQ-019 DONE: pass_led=(fail_cnt==0), fail_led=(fail_cnt!=0), both held; start with mode!=00 re-runs as in REQ-012.
REQ-020 busy=1 in ENC_REQ, DEC_REQ and CHECK only; mode and start changes while busy SHALL be ignored.
REQ-021 disp_byte = byte byte_sel of the last captured pt, byte 0 = bits [7:0]; combinational from byte_sel.
REQ-022 Acks arriving outside the matching REQ state SHALL be ignored; simultaneous enc_ack and dec_ack honour only the ack matching the current state.

Reset
REQ-023 reset SHALL force IDLE with every output 0 (including ct and pt) on the same edge, from any state; a pending req drops immediately.

Configuration
REQ-024 AES_ACK_TIMEOUT_EN defined: a cycle counter runs in ENC_REQ/DEC_REQ; after TIMEOUT_CYCLES cycles without ack, fail_cnt++, req drops and the FSM goes to DONE (abort). Undefined: the FSM waits indefinitely and no counter is synthesised.

Structure
REQ-025 A shared package aes_pkg SHALL hold:
- the state enum;
- mode encodings;
- the polynomial constant 128'h87.
REQ-026 Message stepping SHALL be one sub-module, aes_msg_lfsr: load, step, 128-bit state.

Verification
REQ-027 mode=01, NUM_VECTORS=1, core model returns correct ct/pt: after the run, pass_cnt=1, pass_led=1, byte_sel=0 gives disp_byte=8'hff.
REQ-028 NUM_VECTORS=2: the second enc_data SHALL be 128'h0022446688aacceF1133557799bbddfe.
REQ-029 Decrypt model flips bit 0 on vector 1 of 4: fail_cnt=1, pass_cnt=3, fail_led=1.
REQ-030 reset asserted while enc_req=1: next cycle enc_req=0, busy=0, counters 0, state IDLE.
REQ-031 start with mode=00: no req ever; start with mode=11 then mode changed to 01 mid-run: enc_key_len stays 11.
REQ-032 AES_ACK_TIMEOUT_EN defined, no ack driven: DONE reached after 64 req cycles, fail_cnt=1.
